// File: rtl/respuesta_rx_if.sv
// rtl/respuesta_rx_if.sv - serial return line and decoded byte/acknowledge strobes
interface respuesta_rx_if;
    logic       rx;
    logic [7:0] data;
    logic       data_valid;
    logic       frame_err;
    logic       ok_det;
    logic       err_det;
    logic       busy;

    modport master (
        input  rx,
        output data, data_valid, frame_err, ok_det, err_det, busy
    );

    modport slave (
        output rx,
        input  data, data_valid, frame_err, ok_det, err_det, busy
    );
endinterface

// File: rtl/respuesta_rx.sv
// rtl/respuesta_rx.sv - 8N1 UART receiver with "OK\r\n" / "ERROR\r\n" matcher
module respuesta_rx #(
    parameter int BAUD = 434
) (
    input  logic            clk,
    input  logic            rst,
    respuesta_rx_if.master  bus
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [31:0] OK_SEQ  = 32'h4F4B_0D0A;
    localparam logic [55:0] ERR_SEQ = 56'h45_5252_4F52_0D0A;

    state_t      state, state_nx;
    logic        rx_m, rx_s;
    logic        armed;
    logic [27:0] baud_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic [55:0] hist;
    logic [55:0] hist_nx;
    logic [7:0]  data_r;
    logic        dv_r, fe_r, ok_r, er_r;

    logic        cnt_zero;
    logic        ld_half, ld_full, dec, clr_idx, take_bit, stop_good, stop_bad;

    assign cnt_zero = (baud_cnt == 28'd0);
    assign hist_nx  = {hist[47:0], data_r};

    always_comb begin
        state_nx  = state;
        ld_half   = 1'b0;
        ld_full   = 1'b0;
        dec       = 1'b0;
        clr_idx   = 1'b0;
        take_bit  = 1'b0;
        stop_good = 1'b0;
        stop_bad  = 1'b0;
        case (state)
            IDLE: begin
                // armed blocks retriggering while a break keeps the line low
                if (!rx_s && armed) begin
                    ld_half  = 1'b1;
                    state_nx = START;
                end
            end
            START: begin
                if (!cnt_zero) begin
                    dec = 1'b1;
                end else if (!rx_s) begin
                    ld_full  = 1'b1;
                    clr_idx  = 1'b1;
                    state_nx = DATA;
                end else begin
                    state_nx = IDLE;
                end
            end
            DATA: begin
                if (!cnt_zero) begin
                    dec = 1'b1;
                end else begin
                    take_bit = 1'b1;
                    ld_full  = 1'b1;
                    if (bit_idx == 3'd7) state_nx = STOP;
                end
            end
            STOP: begin
                if (!cnt_zero) begin
                    dec = 1'b1;
                end else begin
                    stop_good = rx_s;
                    stop_bad  = !rx_s;
                    state_nx  = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m     <= 1'b1;
            rx_s     <= 1'b1;
            armed    <= 1'b1;
            baud_cnt <= 28'd0;
            bit_idx  <= 3'd0;
            shreg    <= 8'h00;
        end else begin
            rx_m <= bus.rx;
            rx_s <= rx_m;

            if (stop_bad)
                armed <= 1'b0;
            else if (stop_good || (state == IDLE && rx_s))
                armed <= 1'b1;

            // Reload BAUD-1: the sampling cycle is itself one of the BAUD cycles of a bit
            if (ld_half)
                baud_cnt <= 28'(BAUD / 2);
            else if (ld_full)
                baud_cnt <= 28'(BAUD - 1);
            else if (dec)
                baud_cnt <= baud_cnt - 28'd1;

            if (clr_idx)
                bit_idx <= 3'd0;
            else if (take_bit)
                bit_idx <= bit_idx + 3'd1;

            if (take_bit)
                shreg <= {rx_s, shreg[7:1]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_r <= 8'h00;
            dv_r   <= 1'b0;
            fe_r   <= 1'b0;
            ok_r   <= 1'b0;
            er_r   <= 1'b0;
            hist   <= 56'd0;
        end else begin
            dv_r <= stop_good;
            fe_r <= stop_bad;
            if (stop_good)
                data_r <= shreg;

            if (stop_bad) begin
                hist <= 56'd0;
                ok_r <= 1'b0;
                er_r <= 1'b0;
            end else if (dv_r) begin
                hist <= hist_nx;
                ok_r <= (hist_nx[31:0] == OK_SEQ);
                er_r <= (hist_nx == ERR_SEQ);
            end else begin
                ok_r <= 1'b0;
                er_r <= 1'b0;
            end
        end
    end

    assign bus.data       = data_r;
    assign bus.data_valid = dv_r;
    assign bus.frame_err  = fe_r;
    assign bus.ok_det     = ok_r;
    assign bus.err_det    = er_r;
    assign bus.busy       = (state != IDLE);

endmodule
